// File: rtl/quad_decoder.sv
// Quadrature decoder: 2-flop sync -> debounce -> Gray transition decode -> per-detent accumulator.
// Define QDEC_POS_EN to add the signed step position output pos.
module quad_decoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TRANS_PER_STEP  = 4
`ifdef QDEC_POS_EN
  ,
  parameter int unsigned POS_W = 8
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  input  logic err_clr,
  output logic cw,
  output logic ccw,
  output logic err
`ifdef QDEC_POS_EN
  ,
  output logic [POS_W-1:0] pos
`endif
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned SUB_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic signed [SUB_W-1:0] SUB_MAX = SUB_W'(TRANS_PER_STEP);
  localparam logic signed [SUB_W-1:0] SUB_MIN = -SUB_MAX;

  logic [1:0]             sync1, sync2, cand, db, db_old;
  logic [CNT_W-1:0]       cnt;
  logic                   load_q;
  logic                   base_valid;
  logic signed [SUB_W-1:0] sub, sub_inc_c, sub_dec_c, sub_next_c;
  logic                   illegal_c, pulse_cw_c, pulse_ccw_c;

  // Clockwise successor in the {a,b} Gray sequence 00->10->11->01->00.
  function automatic logic [1:0] cw_next(input logic [1:0] st);
    case (st)
      2'b00:   cw_next = 2'b10;
      2'b10:   cw_next = 2'b11;
      2'b11:   cw_next = 2'b01;
      default: cw_next = 2'b00;
    endcase
  endfunction

  // Synchroniser and debounce filter; load_q marks the edge after a db load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1  <= '0;
      sync2  <= '0;
      cand   <= '0;
      cnt    <= '0;
      db     <= '0;
      db_old <= '0;
      load_q <= 1'b0;
    end else begin
      sync1  <= {a, b};
      sync2  <= sync1;
      load_q <= 1'b0;
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= '0;
      end else begin
        if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
        if (cnt == CNT_LAST) begin
          db_old <= db;
          db     <= cand;
          load_q <= 1'b1;
        end
      end
    end
  end

  assign sub_inc_c = sub + SUB_W'(1);
  assign sub_dec_c = sub - SUB_W'(1);

  // Transition decode and detent accumulation for one db load.
  always_comb begin
    illegal_c   = 1'b0;
    pulse_cw_c  = 1'b0;
    pulse_ccw_c = 1'b0;
    sub_next_c  = sub;
    if (load_q && base_valid && (db != db_old)) begin
      if ((db ^ db_old) == 2'b11) begin
        illegal_c  = 1'b1;
        sub_next_c = '0;
      end else if (db == cw_next(db_old)) begin
        if (sub_inc_c == SUB_MAX) begin
          pulse_cw_c = 1'b1;
          sub_next_c = '0;
        end else begin
          sub_next_c = sub_inc_c;
        end
      end else begin
        if (sub_dec_c == SUB_MIN) begin
          pulse_ccw_c = 1'b1;
          sub_next_c  = '0;
        end else begin
          sub_next_c = sub_dec_c;
        end
      end
    end
  end

  // The first load after reset only establishes the baseline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_valid <= 1'b0;
      sub        <= '0;
      cw         <= 1'b0;
      ccw        <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (load_q) base_valid <= 1'b1;
      sub <= sub_next_c;
      cw  <= pulse_cw_c;
      ccw <= pulse_ccw_c;
      if (illegal_c)    err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

`ifdef QDEC_POS_EN
  // Position tracks emitted pulses, wrapping modulo 2^POS_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            pos <= '0;
    else if (pulse_cw_c)  pos <= pos + POS_W'(1);
    else if (pulse_ccw_c) pos <= pos - POS_W'(1);
  end
`endif

endmodule
